// File: rtl/apu_sample_stream_if.sv
// rtl/apu_sample_stream_if.sv - CPU bus and DAC-side sample signals of the APU sample stream.
interface apu_sample_stream_if #(
   parameter int DATA_W = 16
) ();
   logic              write_i;
   logic              read_i;
   logic [2:0]        addr_i;
   logic [DATA_W-1:0] data_i;
   logic [DATA_W-1:0] data_o;
   logic [DATA_W-1:0] sample_o;
   logic              sample_valid_o;
   logic              intVec_o;

   modport master (
      output write_i, read_i, addr_i, data_i,
      input  data_o, sample_o, sample_valid_o, intVec_o
   );

   modport slave (
      input  write_i, read_i, addr_i, data_i,
      output data_o, sample_o, sample_valid_o, intVec_o
   );
endinterface

// File: rtl/apu_sample_stream.sv
// rtl/apu_sample_stream.sv - APU sample FIFO with divider-paced DAC output and low-watermark irq.
// Optional macro APU_STREAM_UNDERRUN_MUTE_EN: an underrun tick outputs a pulsed zero sample.
module apu_sample_stream #(
   parameter int DEPTH_BITS = 6,
   parameter int DATA_W     = 16,
   parameter int DIV_W      = 16
) (
   input logic               clk_i,
   input logic               reset_i,
   apu_sample_stream_if.slave bus
);
   localparam int DEPTH = 1 << DEPTH_BITS;
   localparam int CW    = DEPTH_BITS + 1;

   localparam logic [2:0] A_DATA   = 3'd0;
   localparam logic [2:0] A_STATUS = 3'd1;
   localparam logic [2:0] A_CTRL   = 3'd2;
   localparam logic [2:0] A_DIV    = 3'd3;
   localparam logic [2:0] A_WMARK  = 3'd4;

   logic [DATA_W-1:0]     mem [DEPTH];
   logic [DEPTH_BITS-1:0] wr_ptr;
   logic [DEPTH_BITS-1:0] rd_ptr;
   logic [CW-1:0]         count;
   logic [CW-1:0]         count_nxt;
   logic [CW-1:0]         wmark;
   logic [DIV_W-1:0]      div;
   logic [DIV_W-1:0]      div_cnt;
   logic                  en;
   logic                  irq_en;
   logic                  ovf;
   logic                  udr;

   logic [DATA_W-1:0]     data_q;
   logic [DATA_W-1:0]     sample_q;
   logic                  sample_valid_q;
   logic                  int_q;

   logic                  is_empty;
   logic                  is_full;
   logic                  tick;
   logic                  pop;
   logic                  udr_tick;
   logic                  wr_data;
   logic                  wr_status;
   logic                  wr_ctrl;
   logic                  wr_div;
   logic                  wr_wmark;
   logic                  push;
   logic [DATA_W-1:0]     status;
   logic [DATA_W-1:0]     rd_val;

   always_comb begin
      is_empty  = (count == '0);
      is_full   = (count == CW'(DEPTH));
      tick      = en && (div_cnt == div);
      pop       = tick && !is_empty;
      udr_tick  = tick && is_empty;
      wr_data   = bus.write_i && (bus.addr_i == A_DATA);
      wr_status = bus.write_i && (bus.addr_i == A_STATUS);
      wr_ctrl   = bus.write_i && (bus.addr_i == A_CTRL);
      wr_div    = bus.write_i && (bus.addr_i == A_DIV);
      wr_wmark  = bus.write_i && (bus.addr_i == A_WMARK);
      // A pop frees the slot this cycle, so a full FIFO still accepts the push.
      push      = wr_data && (!is_full || pop);
   end

   always_comb begin
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + CW'(1);
         2'b01:   count_nxt = count - CW'(1);
         default: count_nxt = count;
      endcase
   end

   always_comb begin
      status                 = '0;
      status[DEPTH_BITS:0]   = count;
      status[12]             = is_empty;
      status[13]             = is_full;
      status[14]             = ovf;
      status[15]             = udr;
   end

   always_comb begin
      rd_val = '0;
      case (bus.addr_i)
         A_STATUS: rd_val = status;
         A_CTRL:   rd_val = DATA_W'({irq_en, en});
         A_DIV:    rd_val = DATA_W'(div);
         A_WMARK:  rd_val = DATA_W'(wmark);
         default:  rd_val = '0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr] <= bus.data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         wmark          <= '0;
         div            <= '0;
         div_cnt        <= '0;
         en             <= 1'b0;
         irq_en         <= 1'b0;
         ovf            <= 1'b0;
         udr            <= 1'b0;
         data_q         <= '0;
         sample_q       <= '0;
         sample_valid_q <= 1'b0;
         int_q          <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + DEPTH_BITS'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + DEPTH_BITS'(1);
         end
         count <= count_nxt;

         // A flag raised in the same cycle as its clear stays set.
         ovf <= (ovf && !(wr_status && bus.data_i[14])) || (wr_data && !push);
         udr <= (udr && !(wr_status && bus.data_i[15])) || udr_tick;

         if (wr_ctrl) begin
            en     <= bus.data_i[0];
            irq_en <= bus.data_i[1];
         end
         if (wr_div) begin
            div <= bus.data_i[DIV_W-1:0];
         end
         if (wr_wmark) begin
            wmark <= bus.data_i[DEPTH_BITS:0];
         end

         if (!en || wr_div || tick) begin
            div_cnt <= '0;
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end

         if (bus.read_i) begin
            data_q <= rd_val;
         end

         if (pop) begin
            sample_q <= mem[rd_ptr];
         end
`ifdef APU_STREAM_UNDERRUN_MUTE_EN
         else if (udr_tick) begin
            sample_q <= '0;
         end
         sample_valid_q <= pop || udr_tick;
`else
         sample_valid_q <= pop;
`endif

         int_q <= irq_en && (count > wmark) && (count_nxt <= wmark);
      end
   end

   assign bus.data_o         = data_q;
   assign bus.sample_o       = sample_q;
   assign bus.sample_valid_o = sample_valid_q;
   assign bus.intVec_o       = int_q;
endmodule

// File: tb/tb_apu_sample_stream.sv
// tb/tb_apu_sample_stream.sv - scoreboard bench for apu_sample_stream with a queue-based reference model.
module tb_apu_sample_stream;
   typedef struct {
      int          cyc;
      logic [15:0] val;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   bit   chk_on = 1'b0;
   int   irq_seen = 0;

   apu_sample_stream_if #(.DATA_W(16)) bus ();

   apu_sample_stream dut (
      .clk_i   (clk),
      .reset_i (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: FIFO contents as a queue, registers as plain integers.
   logic [15:0] m_q [$];
   bit          m_en, m_irq, m_ovf, m_udr;
   int          m_div, m_cnt, m_wm;
   logic [15:0] m_sample;
   logic [15:0] vis_sample = 16'h0;

   exp_t smp_q [$];
   exp_t rd_q  [$];
   int   irq_q [$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, expv);
      end
   endtask

   function automatic logic [15:0] m_status(input int n);
      int s;
      s = n;
      if (n == 0)  s += 16'h1000;
      if (n == 64) s += 16'h2000;
      if (m_ovf)   s += 16'h4000;
      if (m_udr)   s += 16'h8000;
      return 16'(s);
   endfunction

   task automatic step(input bit r, input bit w, input bit rd, input logic [2:0] a, input logic [15:0] d);
      int   n;
      int   old_wm;
      bit   tick;
      bit   old_irq;
      exp_t e;
      @(posedge clk);
      #1;
      rst = r;
      bus.write_i = w;
      bus.read_i  = rd;
      bus.addr_i  = a;
      bus.data_i  = d;
      vis_sample = m_sample;
      if (r) begin
         m_q.delete();
         m_en = 0; m_irq = 0; m_ovf = 0; m_udr = 0;
         m_div = 0; m_cnt = 0; m_wm = 0; m_sample = 16'h0;
      end else begin
         n = m_q.size();
         tick = m_en && (m_cnt == m_div);
         old_irq = m_irq;
         old_wm = m_wm;
         if (rd) begin
            e.cyc = cyc + 1;
            case (a)
               3'd1:    e.val = m_status(n);
               3'd2:    e.val = {14'h0, m_irq, m_en};
               3'd3:    e.val = 16'(m_div);
               3'd4:    e.val = 16'(m_wm);
               default: e.val = 16'h0;
            endcase
            rd_q.push_back(e);
         end
         if (w && a == 3'd1) begin
            if (d[14]) m_ovf = 0;
            if (d[15]) m_udr = 0;
         end
         if (tick) begin
            e.cyc = cyc + 1;
            if (n > 0) begin
               m_sample = m_q.pop_front();
               e.val = m_sample;
               smp_q.push_back(e);
            end else begin
               m_udr = 1;
`ifdef APU_STREAM_UNDERRUN_MUTE_EN
               m_sample = 16'h0;
               e.val = 16'h0;
               smp_q.push_back(e);
`endif
            end
         end
         if (w && a == 3'd0) begin
            if (m_q.size() < 64) m_q.push_back(d);
            else m_ovf = 1;
         end
         if (old_irq && n > old_wm && m_q.size() <= old_wm) irq_q.push_back(cyc + 1);
         if (!m_en || (w && a == 3'd3) || tick) m_cnt = 0;
         else m_cnt = m_cnt + 1;
         if (w && a == 3'd2) begin
            m_en = d[0];
            m_irq = d[1];
         end
         if (w && a == 3'd3) m_div = int'(d);
         if (w && a == 3'd4) m_wm = int'(d[6:0]);
      end
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) step(0, 0, 0, 3'd0, 16'h0);
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      step(0, 1, 0, a, d);
   endtask

   task automatic do_reset();
      step(1, 0, 0, 3'd0, 16'h0);
      step(0, 0, 0, 3'd0, 16'h0);
   endtask

   task automatic rd_check(input logic [2:0] a, input logic [15:0] expv, input string nm);
      step(0, 0, 1, a, 16'h0);
      idle(1);
      @(negedge clk);
      chk(nm, bus.data_o, expv);
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         while (smp_q.size() > 0 && smp_q[0].cyc < cyc) begin
            chk("sample_stale", smp_q[0].cyc, cyc);
            void'(smp_q.pop_front());
         end
         if (smp_q.size() > 0 && smp_q[0].cyc == cyc) begin
            chk("sample_valid", bus.sample_valid_o, 1);
            chk("sample_val", bus.sample_o, smp_q[0].val);
            void'(smp_q.pop_front());
         end else begin
            chk("sample_valid", bus.sample_valid_o, 0);
         end
         chk("sample_o", bus.sample_o, vis_sample);

         while (irq_q.size() > 0 && irq_q[0] < cyc) begin
            chk("irq_stale", irq_q[0], cyc);
            void'(irq_q.pop_front());
         end
         if (irq_q.size() > 0 && irq_q[0] == cyc) begin
            chk("irq", bus.intVec_o, 1);
            void'(irq_q.pop_front());
         end else begin
            chk("irq", bus.intVec_o, 0);
         end
         if (bus.intVec_o === 1'b1) irq_seen++;

         while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
            chk("rdata_stale", rd_q[0].cyc, cyc);
            void'(rd_q.pop_front());
         end
         if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
            chk("rdata", bus.data_o, rd_q[0].val);
            void'(rd_q.pop_front());
         end
      end
   end

   initial begin
      int k;
      int guard;
      bus.write_i = 0;
      bus.read_i  = 0;
      bus.addr_i  = 3'd0;
      bus.data_i  = 16'h0;
      m_sample = 16'h0;

      do_reset();
      chk_on = 1;
      @(negedge clk);
      chk("reset_sample", bus.sample_o, 16'h0);
      chk("reset_irq", bus.intVec_o, 0);
      chk("reset_valid", bus.sample_valid_o, 0);
      rd_check(3'd1, 16'h1000, "reset_status");

      wr(3'd0, 16'h1111);
      wr(3'd0, 16'h2222);
      wr(3'd0, 16'h3333);
      wr(3'd3, 16'd3);
      wr(3'd2, 16'd1);
      idle(18);
      step(0, 0, 1, 3'd1, 16'h0);
      idle(1);
      @(negedge clk);
      chk("underrun_flag", bus.data_o & 16'h8000, 16'h8000);
      wr(3'd2, 16'd0);
      wr(3'd1, 16'hC000);

      for (int i = 0; i < 65; i++) wr(3'd0, 16'($urandom));
      rd_check(3'd1, 16'h6040, "full_status");
      wr(3'd1, 16'hC000);
      rd_check(3'd1, 16'h2040, "cleared_status");
      wr(3'd3, 16'd0);
      wr(3'd2, 16'd1);
      wr(3'd0, 16'hABCD);
      rd_check(3'd1, 16'h2040, "push_on_full_tick");
      for (int i = 0; i < 200; i++) wr(3'd0, 16'($urandom));
      idle(80);
      wr(3'd2, 16'd0);
      wr(3'd1, 16'hC000);

      do_reset();
      wr(3'd4, 16'd2);
      for (int i = 0; i < 5; i++) wr(3'd0, 16'(16'h0100 + i));
      irq_seen = 0;
      wr(3'd2, 16'd3);
      idle(12);
      @(negedge clk);
      chk("irq_count", irq_seen, 1);

      for (int i = 0; i < 1500; i++) begin
         k = $urandom_range(0, 99);
         if (k < 1)       step(1, 0, 0, 3'd0, 16'h0);
         else if (k < 40) wr(3'd0, 16'($urandom));
         else if (k < 50) step(0, 0, 1, 3'($urandom_range(0, 7)), 16'h0);
         else if (k < 55) wr(3'd2, 16'($urandom_range(0, 3)));
         else if (k < 58) wr(3'd3, 16'($urandom_range(0, 4)));
         else if (k < 61) wr(3'd4, 16'($urandom_range(0, 12)));
         else if (k < 63) wr(3'd1, 16'($urandom));
         else if (k < 65) wr(3'($urandom_range(5, 7)), 16'($urandom));
         else if (k < 70) step(0, 1, 1, 3'($urandom_range(0, 1)), 16'($urandom));
         else             idle(1);
      end

      do_reset();
      for (int i = 0; i < 12; i++) wr(3'd0, 16'(16'h0A00 + i));
      wr(3'd3, 16'd1);
      wr(3'd2, 16'd1);
      guard = 0;
      while (m_q.size() > 10 && guard < 100) begin
         idle(1);
         guard++;
      end
      chk("midstream_wait", (guard < 100) ? 1 : 0, 1);
      step(1, 0, 0, 3'd0, 16'h0);
      idle(20);
      rd_check(3'd1, 16'h1000, "post_reset_status");
      rd_check(3'd2, 16'h0000, "post_reset_ctrl");
      @(negedge clk);
      chk("post_reset_sample", bus.sample_o, 16'h0);

      idle(3);
      @(negedge clk);
      chk("smp_left", smp_q.size(), 0);
      chk("irq_left", irq_q.size(), 0);
      chk("rd_left", rd_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/apu_sample_stream.md
Name: apu_sample_stream

Overview:
- Memory-mapped bus responder for the APU region (0x5000–0x5018), replacing the tied-off apu_out.
- Responds to the CPU's 16-bit load/store bus: `write_i`/`read_i` strobes, halfword register address, registered read data.
- CPU pushes 16-bit audio samples into an internal FIFO; a programmable divider pops one sample per period onto the DAC-side output.
- Raises a one-cycle interrupt pulse when the FIFO drains to the low watermark.

Parameters:
- DEPTH_BITS, 6, log2 FIFO depth (64 entries).
- DATA_W, 16, sample and bus data width.
- DIV_W, 16, sample-period divider width.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  synchronous, active-high reset.
- write_i  in  1  bus write strobe (already qualified by region).
- read_i  in  1  bus read strobe (already qualified by region).
- addr_i  in  3  register index (memory_addr[3:1]).
- data_i  in  DATA_W  bus write data.
- data_o  out  DATA_W  bus read data, valid the cycle after `read_i`.
- sample_o  out  DATA_W  current output sample.
- sample_valid_o  out  1  one-cycle pulse when `sample_o` updates from the FIFO.
- intVec_o  out  1  one-cycle low-watermark interrupt pulse.

Behaviour:
- Registers (addr_i):
  - 0 DATA (W): push.
  - 1 STATUS (R: [DEPTH_BITS:0] count, [12] empty, [13] full, [14] overflow, [15] underrun; W: write-1-to-clear bits 14/15).
  - 2 CTRL (RW: [0] enable, [1] irq_en).
  - 3 DIV (RW, period = DIV+1 clocks).
  - 4 WMARK (RW, [DEPTH_BITS:0]).
  - 5–7: reads return 0, writes ignored.
- Reset values: all outputs 0; FIFO empty; count 0; CTRL 0; DIV 0; WMARK 0; sticky flags 0; divider counter 0.
- Read latency: `data_o` registered, valid exactly 1 cycle after `read_i`, held until the next read. Reads have no side effects.
- Write acts on the cycle of `write_i`. Simultaneous `write_i` and `read_i` are both honoured.
- Push, when FIFO not full: store at wr_ptr; wr_ptr wraps modulo 2^DEPTH_BITS; count+1.
- Push when full: data dropped, overflow set sticky.
- Divider:
  - While enable=0: counter held at 0, no ticks.
  - While enable=1: counter increments each cycle. At counter==DIV a tick occurs and counter returns to 0. DIV=0 ticks every cycle.
  - Writing DIV resets the counter to 0.
- On a tick:
  - If FIFO not empty: `sample_o` <= head, rd_ptr wraps, count-1, `sample_valid_o`=1 next cycle.
  - If FIFO empty: `sample_o` held, underrun set sticky, `sample_valid_o`=0.
- Push and pop in the same cycle:
  - Count unchanged.
  - A push into a full FIFO is accepted if a pop occurs that cycle.
  - A push into an empty FIFO is not visible to a same-cycle pop; the tick underruns.
- Interrupt: `intVec_o`=1 for one cycle when irq_en=1 and count transitions from >WMARK to <=WMARK. No repeat while count stays <=WMARK.
- Clearing enable mid-stream: FIFO contents and `sample_o` are preserved.
- reset_i asserted at any time: immediate return to reset state next edge, FIFO flushed.

Optional Feature:
- Macro: APU_STREAM_UNDERRUN_MUTE_EN.
- Defined: an underrun tick drives `sample_o` to 0 and pulses `sample_valid_o`.
- Undefined: an underrun tick holds the last sample and produces no pulse.
- Sticky underrun flag behaviour is identical in both builds.

Test Plan:
- Reset, then read STATUS -> `data_o`=0x1000 (empty, count 0) one cycle after `read_i`. `sample_o`=0, `intVec_o`=0.
- Push 0x1111, 0x2222, 0x3333; DIV=3; CTRL=1 -> `sample_valid_o` pulses every 4 clocks, `sample_o` 0x1111, 0x2222, 0x3333. Fourth tick sets STATUS[15]; `sample_o` holds 0x3333, or is 0x0000 with APU_STREAM_UNDERRUN_MUTE_EN.
- Push 65 words, enable=0 -> count=64, STATUS[13]=1, STATUS[14]=1; 65th word never emitted. Write 0xC000 to STATUS -> bits 14/15 clear.
- WMARK=2, CTRL=3, DIV=0, 5 samples queued -> single `intVec_o` pulse on the cycle count reaches 2; none afterward.
- FIFO full with DIV=0 enabled; push on a tick cycle -> accepted, count stays 64, no overflow. Ptr wrap verified by 200 streamed samples emitted in order.
- Assert reset_i mid-stream with count=10 -> next cycle count=0, `sample_o`=0, CTRL=0, no further ticks.
